// File: rtl/data_memory_sequencer.sv
// Drives data_memory_manager's address-write / read / write strobe sequence for
// 1..MAX_BEATS byte bursts with post-increment addressing, packing load bytes into a word.
module data_memory_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 4,
   localparam int LEN_WIDTH  = $clog2(MAX_BEATS),
   localparam int WORD_WIDTH = MAX_BEATS * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_req,
   input  logic                  in_op,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [LEN_WIDTH-1:0]  in_len,
   input  logic [WORD_WIDTH-1:0] in_wdata,
   output logic                  out_busy,
   output logic                  out_done,
   output logic [WORD_WIDTH-1:0] out_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_addr_write_en,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, ADDR, READ, CAPT, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic                  op_q, op_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  addr_we_q, addr_we_d;
   logic                  read_en_q, read_en_d;
   logic                  write_en_q, write_en_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      len_d   = len_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         IDLE: begin
            if (in_req) begin
               op_d    = in_op;
               addr_d  = in_addr;
               len_d   = in_len;
               wdata_d = in_wdata;
               beat_d  = '0;
               rdata_d = '0;
               state_d = ADDR;
            end
         end
         ADDR:  state_d = op_q ? WRITE : READ;
         READ:  state_d = CAPT;
         CAPT, WRITE: begin
            if (state_q == CAPT) begin
               for (int i = 0; i < MAX_BEATS; i++) begin
                  if (beat_q == LEN_WIDTH'(i)) begin
                     rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                  end
               end
            end
            // Address wraps naturally at the top of the address space.
            if (beat_q == len_q) begin
               state_d = DONE;
            end else begin
               beat_d  = beat_q + LEN_WIDTH'(1);
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = ADDR;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in the matching cycle.
   always_comb begin
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      addr_we_d   = (state_d == ADDR);
      read_en_d   = (state_d == READ) || (state_d == CAPT);
      write_en_d  = (state_d == WRITE);
      mem_addr_d  = (state_d inside {ADDR, READ, CAPT, WRITE}) ? addr_d : '0;
      mem_wdata_d = '0;
      for (int i = 0; i < MAX_BEATS; i++) begin
         if (state_d == WRITE && beat_d == LEN_WIDTH'(i)) begin
            mem_wdata_d = wdata_d[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 1'b0;
         len_q       <= '0;
         beat_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         addr_we_q   <= 1'b0;
         read_en_q   <= 1'b0;
         write_en_q  <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         addr_we_q   <= addr_we_d;
         read_en_q   <= read_en_d;
         write_en_q  <= write_en_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign out_busy          = busy_q;
   assign out_done          = done_q;
   assign out_rdata         = rdata_q;
   assign mem_addr          = mem_addr_q;
   assign mem_addr_write_en = addr_we_q;
   assign mem_read_en       = read_en_q;
   assign mem_write_en      = write_en_q;
   assign mem_wdata         = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_sequencer.sv
// Self-checking bench for data_memory_sequencer: a simple memory-manager stand-in feeds
// the DUT, and a transaction-level timing/data model predicts every output each cycle.
module tb_data_memory_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_req = 1'b0;
   logic        in_op = 1'b0;
   logic [9:0]  in_addr = '0;
   logic [1:0]  in_len = '0;
   logic [31:0] in_wdata = '0;
   logic        out_busy, out_done;
   logic [31:0] out_rdata;
   logic [9:0]  mem_addr;
   logic        mem_addr_write_en, mem_read_en, mem_write_en;
   logic [7:0]  mem_wdata;
   logic [7:0]  mgr_rdata = '0;

   int nChecks = 0;
   int nFails  = 0;

   data_memory_sequencer dut (
      .clk(clk), .rst(rst),
      .in_req(in_req), .in_op(in_op), .in_addr(in_addr), .in_len(in_len), .in_wdata(in_wdata),
      .out_busy(out_busy), .out_done(out_done), .out_rdata(out_rdata),
      .mem_addr(mem_addr), .mem_addr_write_en(mem_addr_write_en),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_wdata(mem_wdata), .mem_rdata(mgr_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Memory-manager stand-in: latches the address on addr_write, reads/writes on the strobes.
   logic [7:0] mgrMem [1024];
   logic [9:0] mgrAddr = '0;
   logic [3:0] inPort = '0;
   logic [3:0] outPort = '0;

   always @(posedge clk) begin
      if (mem_addr_write_en) mgrAddr <= mem_addr;
      if (mem_write_en) begin
         if (mgrAddr == 10'h3FF) outPort <= mem_wdata[3:0];
         else if (mgrAddr != 10'h3FE) mgrMem[mgrAddr] <= mem_wdata;
      end
      if (mem_read_en) begin
         if (mgrAddr == 10'h3FE) mgrRdataNext(8'({4'b0, inPort}));
         else if (mgrAddr == 10'h3FF) mgrRdataNext(8'({4'b0, outPort}));
         else mgrRdataNext(mgrMem[mgrAddr]);
      end
   end

   task automatic mgrRdataNext(input logic [7:0] v);
      mgr_rdata <= v;
   endtask

   // Reference memory with the same port semantics, updated at transaction level.
   logic [7:0] refMem [1024];
   logic [3:0] refInPort = '0;
   logic [3:0] refOutPort = '0;

   function automatic logic [7:0] refRead(input logic [9:0] a);
      if (a == 10'h3FE) return {4'b0, refInPort};
      if (a == 10'h3FF) return {4'b0, refOutPort};
      return refMem[a];
   endfunction

   task automatic refWrite(input logic [9:0] a, input logic [7:0] d);
      if (a == 10'h3FF) refOutPort = d[3:0];
      else if (a != 10'h3FE) refMem[a] = d;
   endtask

   // Timing model: a burst accepted into cycle A occupies 3 cycles per load beat or
   // 2 per store beat, then one DONE cycle; the FSM is free again the cycle after DONE.
   int          cyc = 0;
   bit          act = 1'b0;
   int          aCyc = 0, dCyc = 0;
   bit          tOp = 1'b0;
   logic [9:0]  tAddr = '0;
   logic [31:0] tWdata = '0;
   logic [31:0] mRdata = '0;

   always @(posedge clk) begin
      int ended, off;
      ended = cyc;
      cyc++;
      if (rst) begin
         act    = 1'b0;
         mRdata = '0;
      end else begin
         if (act && ended < dCyc) begin
            off = ended - aCyc;
            if (!tOp && off % 3 == 2) mRdata[8*(off/3) +: 8] = refRead(tAddr + 10'(off/3));
            if (tOp && off % 2 == 1) refWrite(tAddr + 10'(off/2), tWdata[8*(off/2) +: 8]);
         end
         if ((!act || ended > dCyc) && in_req) begin
            act    = 1'b1;
            aCyc   = cyc;
            tOp    = in_op;
            tAddr  = in_addr;
            tWdata = in_wdata;
            dCyc   = aCyc + (in_op ? 2 : 3) * (int'(in_len) + 1);
            mRdata = '0;
         end
      end
   end

   // Compare process: every output against the model, every cycle, away from the active edge.
   always @(negedge clk) begin
      int off, b;
      logic eBusy, eDone, eAwe, eRe, eWe;
      logic [9:0] eAddr;
      logic [7:0] eWd;
      eBusy = 0; eDone = 0; eAwe = 0; eRe = 0; eWe = 0; eAddr = '0; eWd = '0;
      if (!rst && act && cyc <= dCyc) begin
         eBusy = 1'b1;
         if (cyc == dCyc) begin
            eDone = 1'b1;
         end else begin
            off = cyc - aCyc;
            b   = tOp ? off / 2 : off / 3;
            if (!tOp) begin
               eAwe = (off % 3 == 0);
               eRe  = (off % 3 != 0);
            end else begin
               eAwe = (off % 2 == 0);
               eWe  = (off % 2 == 1);
               if (eWe) eWd = tWdata[8*b +: 8];
            end
            eAddr = tAddr + 10'(b);
         end
      end
      checkOutput("busy", 32'(out_busy), 32'(eBusy));
      checkOutput("done", 32'(out_done), 32'(eDone));
      checkOutput("addr_write_en", 32'(mem_addr_write_en), 32'(eAwe));
      checkOutput("read_en", 32'(mem_read_en), 32'(eRe));
      checkOutput("write_en", 32'(mem_write_en), 32'(eWe));
      checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(eWd));
      checkOutput("rdata", out_rdata, rst ? 32'h0 : mRdata);
      checkOutput("out_port", 32'(outPort), 32'(refOutPort));
   end

   // Issues one request and measures the cycle (after the accepting edge) in which done pulses.
   task automatic applyStimulus(input bit op, input logic [9:0] addr, input logic [1:0] len,
                                input logic [31:0] wd, output int lat);
      @(negedge clk); #1;
      in_req = 1'b1; in_op = op; in_addr = addr; in_len = len; in_wdata = wd;
      @(posedge clk); #1;
      in_req = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (out_done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) checkOutput("done_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, dn, aw;
      bit op;
      logic [1:0] len;
      for (int i = 0; i < 1024; i++) begin
         mgrMem[i] = 8'(i ^ 8'h5A);
         refMem[i] = 8'(i ^ 8'h5A);
      end

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(out_busy), 32'h0);
      checkOutput("reset_rdata", out_rdata, 32'h0);
      checkOutput("reset_addr", 32'(mem_addr), 32'h0);
      #1 rst = 1'b0;

      // Single-beat store then load back
      applyStimulus(1'b1, 10'h00F, 2'd0, 32'h99, lat);
      checkOutput("t1_store_lat", 32'(lat), 32'd3);
      applyStimulus(1'b0, 10'h00F, 2'd0, 32'h0, lat);
      checkOutput("t1_load_lat", 32'(lat), 32'd4);
      checkOutput("t1_rdata", out_rdata, 32'h0000_0099);

      // Output port
      applyStimulus(1'b1, 10'h3FF, 2'd0, 32'h8C, lat);
      checkOutput("t2_lat", 32'(lat), 32'd3);
      checkOutput("t2_out_port", 32'(outPort), 32'hC);

      // Input port
      inPort = 4'b0001; refInPort = 4'b0001;
      applyStimulus(1'b0, 10'h3FE, 2'd0, 32'h0, lat);
      checkOutput("t3_lat", 32'(lat), 32'd4);
      checkOutput("t3_rdata", out_rdata, 32'h0000_0001);

      // Wrapping 4-beat store, 2-beat load from the wrapped region
      applyStimulus(1'b1, 10'h3FE, 2'd3, 32'h4433_2211, lat);
      checkOutput("t4_store_lat", 32'(lat), 32'd9);
      checkOutput("t4_out_port", 32'(outPort), 32'h2);
      applyStimulus(1'b0, 10'h000, 2'd1, 32'h0, lat);
      checkOutput("t4_load_lat", 32'(lat), 32'd7);
      checkOutput("t4_rdata", out_rdata, 32'h0000_4433);

      // Request pulse while busy is dropped
      @(negedge clk); #1;
      in_req = 1'b1; in_op = 1'b1; in_addr = 10'h100; in_len = 2'd1; in_wdata = 32'h0000_BBAA;
      @(posedge clk); #1 in_req = 1'b0;
      dn = 0; aw = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         dn += int'(out_done);
         aw += int'(mem_addr_write_en);
         if (i == 1) begin
            #1 in_req = 1'b1; in_op = 1'b0; in_addr = 10'h200; in_len = 2'd3;
            @(posedge clk); #1 in_req = 1'b0;
         end
      end
      checkOutput("t5_done_count", 32'(dn), 32'd1);
      checkOutput("t5_addr_strobes", 32'(aw), 32'd2);

      // Reset during CAPT of the second beat
      @(negedge clk); #1;
      in_req = 1'b1; in_op = 1'b0; in_addr = 10'h010; in_len = 2'd2;
      @(posedge clk); #1 in_req = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("t6_in_capt", 32'(mem_read_en), 32'h1);
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_rst_outputs",
                  32'({out_busy, out_done, mem_addr_write_en, mem_read_en, mem_write_en, mem_addr, mem_wdata}),
                  32'h0);
      checkOutput("t6_rst_rdata", out_rdata, 32'h0);
      @(negedge clk); #1 rst = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         dn += int'(out_done);
      end
      checkOutput("t6_no_done", 32'(dn), 32'd0);
      applyStimulus(1'b0, 10'h00F, 2'd0, 32'h0, lat);
      checkOutput("t6_after_lat", 32'(lat), 32'd4);
      checkOutput("t6_after_rdata", out_rdata, 32'h0000_0099);

      // Randomized bursts against the model
      for (int i = 0; i < 40; i++) begin
         op  = 1'($urandom);
         len = 2'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(op, 10'($urandom), len, $urandom, lat);
         checkOutput("rand_lat", 32'(lat), 32'((op ? 2 : 3) * (int'(len) + 1) + 1));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
